rv32_lsu_buffered: RTL

//   Memory-stage load/store unit, successor to the combinational LSU. Adds byte/half/word lane

---
 rtl/rv32_lsu_buffered_pkg.sv | 32 +++
 rtl/rv32_store_buffer.sv | 54 +++++
 rtl/rv32_lsu_buffered.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rv32_lsu_buffered_pkg.sv
// Shared types for the buffered load/store unit: memory op encoding, load FSM states
// and the store-buffer entry layout.
package rv32_types;

    typedef enum logic [3:0] {
        MEM_NOP,
        MEM_LB,
        MEM_LH,
        MEM_LW,
        MEM_LBU,
        MEM_LHU,
        MEM_SB,
        MEM_SH,
        MEM_SW
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LD_REQ,
        ST_LD_WAIT
    } lsu_state_t;

    // Entries always carry a 32-bit word address; the top narrows/widens to ADDR_W.
    localparam int SB_ADDR_W = 32;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [3:0]           be;
        logic [31:0]          wdata;
    } sb_entry_t;

endpackage

// File: rtl/rv32_store_buffer.sv
// Posted-store FIFO. Only pointers and occupancy are reset; entry storage is plain
// flops so stale contents after reset are never visible (empty gates the head).
module rv32_store_buffer
    import rv32_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      push,
    input  sb_entry_t push_entry,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output sb_entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);

    sb_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/rv32_lsu_buffered.sv
// Memory-stage LSU: lane steering, load extension, misalignment detection, a posted
// store buffer and a single-outstanding valid/ready bus with a load response timeout.
module rv32_lsu_buffered
    import rv32_types::*;
#(
    parameter int SB_DEPTH       = 4,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              ready,
    output logic [31:0]       load_data,
    output logic              misaligned,
    output logic              bus_error,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_we,
    output logic [3:0]        mem_req_be,
    output logic [31:0]       mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_rdata
);

    localparam int CTR_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    mem_op_t           op;
    lsu_state_t        state, state_nx;
    logic [CTR_W-1:0]  ctr;
    logic              ctr_clr, ctr_inc;
    logic              ignore_rsp, ignore_set;
    logic              is_load, is_store, is_half, is_word, mis;
    logic [1:0]        a;
    logic [ADDR_W-1:0] waddr;
    logic [3:0]        st_be;
    logic [31:0]       st_data;
    logic [7:0]        rsp_byte;
    logic [15:0]       rsp_half;
    logic [31:0]       ld_ext;
    logic              sb_push, sb_pop, sb_full, sb_empty;
    sb_entry_t         sb_in, sb_head;

    assign op       = mem_op_t'(req_op);
    assign a        = req_addr[1:0];
    assign waddr    = {req_addr[ADDR_W-1:2], 2'b00};
    assign is_load  = op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    assign is_store = op inside {MEM_SB, MEM_SH, MEM_SW};
    assign is_half  = op inside {MEM_LH, MEM_LHU, MEM_SH};
    assign is_word  = op inside {MEM_LW, MEM_SW};
    assign mis      = (is_half && a[0]) || (is_word && (a != 2'b00));

    always_comb begin
        st_be   = 4'b1111;
        st_data = req_wdata;
        case (op)
            MEM_SB: begin
                st_be   = 4'b0001 << a;
                st_data = {4{req_wdata[7:0]}};
            end
            MEM_SH: begin
                st_be   = a[1] ? 4'b1100 : 4'b0011;
                st_data = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign sb_in = '{addr: SB_ADDR_W'(waddr), be: st_be, wdata: st_data};

    assign rsp_byte = mem_rsp_rdata[{a, 3'b000} +: 8];
    assign rsp_half = a[1] ? mem_rsp_rdata[31:16] : mem_rsp_rdata[15:0];

    always_comb begin
        ld_ext = mem_rsp_rdata;
        case (op)
            MEM_LB:  ld_ext = {{24{rsp_byte[7]}}, rsp_byte};
            MEM_LBU: ld_ext = {24'b0, rsp_byte};
            MEM_LH:  ld_ext = {{16{rsp_half[15]}}, rsp_half};
            MEM_LHU: ld_ext = {16'b0, rsp_half};
            default: ;
        endcase
    end

    rv32_store_buffer #(.DEPTH(SB_DEPTH)) u_sb (
        .clk        (clk),
        .resetn     (resetn),
        .push       (sb_push),
        .push_entry (sb_in),
        .pop        (sb_pop),
        .full       (sb_full),
        .empty      (sb_empty),
        .head       (sb_head)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            ctr        <= '0;
            ignore_rsp <= 1'b0;
        end else begin
            state <= state_nx;
            if (ctr_clr)      ctr <= '0;
            else if (ctr_inc) ctr <= ctr + CTR_W'(1);
            // A response after a timeout belongs to the abandoned load; swallow exactly one.
            if (ignore_set)         ignore_rsp <= 1'b1;
            else if (mem_rsp_valid) ignore_rsp <= 1'b0;
        end
    end

    always_comb begin
        state_nx      = state;
        ready         = 1'b0;
        misaligned    = 1'b0;
        bus_error     = 1'b0;
        load_data     = '0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        mem_req_we    = 1'b0;
        mem_req_be    = '0;
        mem_req_wdata = '0;
        sb_push       = 1'b0;
        sb_pop        = 1'b0;
        ctr_clr       = 1'b0;
        ctr_inc       = 1'b0;
        ignore_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!is_load && !is_store) begin
                    ready = 1'b1;
                end else if (mis) begin
                    ready      = 1'b1;
                    misaligned = 1'b1;
                end else if (is_store) begin
                    sb_push = !sb_full;
                    ready   = !sb_full;
                end else if (sb_empty) begin
                    state_nx = ST_LD_REQ;
                end
                // Drain only from IDLE so a load never overtakes an older store.
                if (!sb_empty) begin
                    mem_req_valid = 1'b1;
                    mem_req_we    = 1'b1;
                    mem_req_addr  = ADDR_W'(sb_head.addr);
                    mem_req_be    = sb_head.be;
                    mem_req_wdata = sb_head.wdata;
                    sb_pop        = mem_req_ready;
                end
            end
            ST_LD_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = waddr;
                mem_req_be    = 4'b1111;
                if (mem_req_ready) begin
                    state_nx = ST_LD_WAIT;
                    ctr_clr  = 1'b1;
                end
            end
            ST_LD_WAIT: begin
                ctr_inc = 1'b1;
                if (mem_rsp_valid && !ignore_rsp) begin
                    ready     = 1'b1;
                    load_data = ld_ext;
                    state_nx  = ST_IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (ctr == CTR_W'(TMO_LAST))) begin
                    ready      = 1'b1;
                    bus_error  = 1'b1;
                    ignore_set = 1'b1;
                    state_nx   = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule
